cache_instructions: RTL and testbench

//  Read-only, direct-mapped instruction cache between the CPU fetch port and burst_ram.
//  A hit returns the instruction word one cycle after the request.
//  A miss fetches the whole line with one read burst.
//  The requested word is returned as soon as its beat arrives; busy stays high until the line fill completes.

---
 rtl/cache_instructions.sv | 204 ++++++++++++++++++++
 tb/tb_cache_instructions.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_instructions.sv
// ============================================================================
// Module  : cache_instructions
// Brief   : Read-only direct-mapped instruction cache in front of burst_ram.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_instructions #(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [ADDRESS_BITWIDTH-1:0]        address,
    output logic [DATA_BITWIDTH-1:0]           data,
    output logic                               data_ready,
    output logic                               busy,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
);

    localparam int LINES     = 1 << LINE_IX_BITWIDTH;
    localparam int WORDS     = 1 << DATA_IX_IN_LINE_BITWIDTH;
    localparam int WPB       = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int WPB_BITS  = $clog2(WPB);
    localparam int BEAT_BITS = $clog2(RAM_BURST_DATA_COUNT);
    localparam int WA_BITS   = ADDRESS_BITWIDTH - 2;
    localparam int TAG_BITS  = WA_BITS - DATA_IX_IN_LINE_BITWIDTH - LINE_IX_BITWIDTH;
    localparam int DIX       = DATA_IX_IN_LINE_BITWIDTH;
    localparam int LIX       = LINE_IX_BITWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [WA_BITS-1:0]              waddr_q, waddr_d;
    logic [DATA_BITWIDTH-1:0]        data_q, data_d;
    logic                            data_ready_q, data_ready_d;
    logic                            busy_q, busy_d;
    logic                            br_cmd_en_q, br_cmd_en_d;
    logic [RAM_DEPTH_BITWIDTH-1:0]   br_addr_q, br_addr_d;
    logic [BEAT_BITS-1:0]            beat_q, beat_d;
    logic [LINES-1:0]                valid_q, valid_d;
    logic [TAG_BITS-1:0]             tag_q [LINES];
    logic [TAG_BITS-1:0]             tag_d [LINES];
    logic [31:0]                     stat_cache_hits, stat_cache_hits_d;
    logic [31:0]                     stat_cache_misses, stat_cache_misses_d;

    logic [DATA_BITWIDTH-1:0]        line_mem [LINES][WORDS];

    logic [WA_BITS-1:0]              w_req_wa;
    logic [LIX-1:0]                  w_req_line;
    logic [DIX-1:0]                  w_req_word;
    logic [TAG_BITS-1:0]             w_req_tag;
    logic                            w_hit;
    logic [LIX-1:0]                  w_fill_line;
    logic [DIX-1:0]                  w_fill_word;
    logic [TAG_BITS-1:0]             w_fill_tag;
    logic                            w_fill_we;
    logic [DATA_BITWIDTH-1:0]        w_beat_words [WPB];
    logic                            w_unused_addr_bits;

    assign w_unused_addr_bits = ^address[1:0];

    assign w_req_wa    = address[ADDRESS_BITWIDTH-1:2];
    assign w_req_word  = w_req_wa[DIX-1:0];
    assign w_req_line  = w_req_wa[DIX+LIX-1:DIX];
    assign w_req_tag   = w_req_wa[WA_BITS-1:DIX+LIX];
    assign w_hit       = valid_q[w_req_line] && (tag_q[w_req_line] == w_req_tag);

    assign w_fill_word = waddr_q[DIX-1:0];
    assign w_fill_line = waddr_q[DIX+LIX-1:DIX];
    assign w_fill_tag  = waddr_q[WA_BITS-1:DIX+LIX];
    assign w_fill_we   = (state_q == S_FILL) && br_rd_data_valid;

    always_comb begin
        for (int k = 0; k < WPB; k++) begin
            w_beat_words[k] = br_rd_data[k*DATA_BITWIDTH +: DATA_BITWIDTH];
        end
    end

    always_comb begin
        state_d             = state_q;
        waddr_d             = waddr_q;
        data_d              = data_q;
        data_ready_d        = data_ready_q;
        busy_d              = busy_q;
        br_cmd_en_d         = 1'b0;
        br_addr_d           = br_addr_q;
        beat_d              = beat_q;
        valid_d             = valid_q;
        tag_d               = tag_q;
        stat_cache_hits_d   = stat_cache_hits;
        stat_cache_misses_d = stat_cache_misses;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    waddr_d      = w_req_wa;
                    data_ready_d = 1'b0;
                    if (w_hit) begin
                        data_d            = line_mem[w_req_line][w_req_word];
                        data_ready_d      = 1'b1;
                        stat_cache_hits_d = stat_cache_hits + 32'd1;
                    end else begin
                        stat_cache_misses_d = stat_cache_misses + 32'd1;
                        busy_d              = 1'b1;
                        valid_d[w_req_line] = 1'b0;
                        state_d             = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (!br_busy) begin
                    br_cmd_en_d = 1'b1;
                    // Line-aligned burst-word address: line number scaled by beats per line.
                    br_addr_d   = RAM_DEPTH_BITWIDTH'({waddr_q[WA_BITS-1:DIX], {BEAT_BITS{1'b0}}});
                    beat_d      = '0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                if (br_rd_data_valid) begin
                    beat_d = beat_q + BEAT_BITS'(1);
                    if (w_fill_word[DIX-1:WPB_BITS] == beat_q) begin
                        data_d       = w_beat_words[w_fill_word[WPB_BITS-1:0]];
                        data_ready_d = 1'b1;
                    end
                    if (beat_q == BEAT_BITS'(RAM_BURST_DATA_COUNT - 1)) begin
                        tag_d[w_fill_line]   = w_fill_tag;
                        valid_d[w_fill_line] = 1'b1;
                        busy_d               = 1'b0;
                        state_d              = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            waddr_q           <= '0;
            data_q            <= '0;
            data_ready_q      <= 1'b0;
            busy_q            <= 1'b0;
            br_cmd_en_q       <= 1'b0;
            br_addr_q         <= '0;
            beat_q            <= '0;
            valid_q           <= '0;
            stat_cache_hits   <= '0;
            stat_cache_misses <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            waddr_q           <= waddr_d;
            data_q            <= data_d;
            data_ready_q      <= data_ready_d;
            busy_q            <= busy_d;
            br_cmd_en_q       <= br_cmd_en_d;
            br_addr_q         <= br_addr_d;
            beat_q            <= beat_d;
            valid_q           <= valid_d;
            stat_cache_hits   <= stat_cache_hits_d;
            stat_cache_misses <= stat_cache_misses_d;
            tag_q             <= tag_d;
        end
    end

    // Data array carries no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            for (int k = 0; k < WPB; k++) begin
                line_mem[w_fill_line][{beat_q, WPB_BITS'(k)}] <= w_beat_words[k];
            end
        end
    end

    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign br_cmd     = 1'b0;
    assign br_cmd_en  = br_cmd_en_q;
    assign br_addr    = br_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_instructions.sv
// ============================================================================
// Module  : tb_cache_instructions
// Brief   : Directed self-checking bench for cache_instructions with a burst_ram model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_instructions;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data;
    logic        data_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_rd_data = '0;
    logic        br_rd_data_valid = 1'b0;
    logic        br_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    cache_instructions dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .data             (data),
        .data_ready       (data_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    // burst_ram model: 3-cycle latency, 4 beats per burst.
    logic [63:0] ram [16];
    int          ram_t = -1;
    logic [3:0]  ram_a = '0;

    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        if (br_cmd_en && !br_busy) begin
            ram_t   <= 0;
            ram_a   <= br_addr;
            br_busy <= 1'b1;
        end else if (ram_t >= 0) begin
            if (ram_t + 1 >= 3) begin
                br_rd_data_valid <= 1'b1;
                br_rd_data       <= ram[ram_a + 4'(ram_t - 2)];
            end
            if (ram_t + 1 == 6) begin
                ram_t   <= -1;
                br_busy <= 1'b0;
            end else begin
                ram_t <= ram_t + 1;
            end
        end
    end

    int         cmd_count  = 0;
    int         beat_count = 0;
    logic [3:0] last_br_addr = '0;

    always @(negedge clk) begin
        if (br_cmd_en) begin
            cmd_count++;
            last_br_addr = br_addr;
        end
        if (br_rd_data_valid) beat_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request at a negedge; lat/idle_at count rising edges until data_ready/!busy.
    task automatic fetch(input logic [31:0] a, output int lat, output int idle_at);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        enable  = 1'b1;
        address = a;
        @(negedge clk);
        enable = 1'b0;
        lat    = 1;
        while (data_ready !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        idle_at = lat;
        while (busy !== 1'b0 && idle_at < 100) begin
            @(negedge clk);
            idle_at++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idle, c0, b0;

        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[0]  = {32'h3F5A2E14, 32'hB7C6A980};
        ram[1]  = {32'h00000000, 32'hAB4C3E6F};
        ram[2]  = {32'h00000000, 32'hD5B8A9C4};
        ram[3]  = {32'h600DF00D, 32'h00000000};
        ram[4]  = {32'h00000000, 32'h2F5E3C7A};
        ram[8]  = {32'h0A1B2C3D, 32'h00000000};
        ram[11] = {32'h00000000, 32'h5EED1234};

        repeat (3) @(negedge clk);
        chk("rst_data",       data,                      32'h0);
        chk("rst_data_ready", {31'b0, data_ready},       32'h0);
        chk("rst_busy",       {31'b0, busy},             32'h0);
        chk("rst_cmd_en",     {31'b0, br_cmd_en},        32'h0);
        chk("rst_cmd",        {31'b0, br_cmd},           32'h0);
        chk("rst_br_addr",    {28'b0, br_addr},          32'h0);
        chk("rst_hits",       dut.stat_cache_hits,       32'd0);
        chk("rst_misses",     dut.stat_cache_misses,     32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss on line 0
        c0 = cmd_count; b0 = beat_count;
        fetch(32'h00, lat, idle);
        chk("a0_data",    data,                   32'hB7C6A980);
        chk("a0_lat",     32'(lat),               32'd7);
        chk("a0_idle",    32'(idle),              32'd10);
        chk("a0_beats",   32'(beat_count - b0),   32'd4);
        chk("a0_cmds",    32'(cmd_count - c0),    32'd1);
        chk("a0_braddr",  {28'b0, last_br_addr},  32'd0);
        chk("a0_misses",  dut.stat_cache_misses,  32'd1);
        chk("a0_hits",    dut.stat_cache_hits,    32'd0);

        // Hits in the filled line
        c0 = cmd_count;
        fetch(32'h04, lat, idle);
        chk("a4_data",  data,                32'h3F5A2E14);
        chk("a4_lat",   32'(lat),            32'd1);
        chk("a4_hits",  dut.stat_cache_hits, 32'd1);
        fetch(32'h08, lat, idle);
        chk("a8_data",  data,                32'hAB4C3E6F);
        chk("a8_lat",   32'(lat),            32'd1);
        chk("a8_hits",  dut.stat_cache_hits, 32'd2);
        fetch(32'h10, lat, idle);
        chk("a16_data", data,                32'hD5B8A9C4);
        chk("a16_hits", dut.stat_cache_hits, 32'd3);
        chk("hit_cmds", 32'(cmd_count - c0), 32'd0);

        // Miss on line 1, line 0 must stay valid
        fetch(32'h20, lat, idle);
        chk("a32_data",   data,                   32'h2F5E3C7A);
        chk("a32_lat",    32'(lat),               32'd7);
        chk("a32_braddr", {28'b0, last_br_addr},  32'd4);
        chk("a32_misses", dut.stat_cache_misses,  32'd2);
        c0 = cmd_count;
        fetch(32'h04, lat, idle);
        chk("l0_keep_data", data,                32'h3F5A2E14);
        chk("l0_keep_hits", dut.stat_cache_hits, 32'd4);
        chk("l0_keep_cmds", 32'(cmd_count - c0), 32'd0);

        // Eviction of line 0 by tag 1, then refetch of tag 0 misses
        fetch(32'h44, lat, idle);
        chk("a68_data",   data,                   32'h0A1B2C3D);
        chk("a68_braddr", {28'b0, last_br_addr},  32'd8);
        chk("a68_misses", dut.stat_cache_misses,  32'd3);
        fetch(32'h00, lat, idle);
        chk("re0_data",   data,                   32'hB7C6A980);
        chk("re0_misses", dut.stat_cache_misses,  32'd4);

        // Reset in the middle of a line fill
        enable  = 1'b1;
        address = 32'h44;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy",   {31'b0, busy},          32'h0);
        chk("mid_rst_ready",  {31'b0, data_ready},    32'h0);
        chk("mid_rst_data",   data,                   32'h0);
        chk("mid_rst_braddr", {28'b0, br_addr},       32'h0);
        chk("mid_rst_misses", dut.stat_cache_misses,  32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        fetch(32'h44, lat, idle);
        chk("post_data",   data,                  32'h0A1B2C3D);
        chk("post_misses", dut.stat_cache_misses, 32'd1);
        chk("post_hits",   dut.stat_cache_hits,   32'd0);
        fetch(32'h58, lat, idle);
        chk("a58_data", data,                32'h5EED1234);
        chk("a58_lat",  32'(lat),            32'd1);
        chk("a58_hits", dut.stat_cache_hits, 32'd1);

        // Requested word in the last beat: data_ready coincides with fill end
        fetch(32'h1C, lat, idle);
        chk("a28_data",   data,                  32'h600DF00D);
        chk("a28_lat",    32'(lat),              32'd10);
        chk("a28_idle",   32'(idle),             32'd10);
        chk("a28_misses", dut.stat_cache_misses, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
